// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - fetch-to-decode instruction FIFO presenting the head entry as dispatch fields
// Optional feature macro: RV32E_REGCHK_EN (drives dec_ill with an RV32E register-index check)
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            fetch_vld,
  output logic            fetch_rdy,
  input  logic [31:0]     fetch_ins,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            dec_vld,
  input  logic            dec_rdy,
  output logic [XLEN-1:0] dec_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [3:0]      rd,
  output logic [4:0]      shamt,
  output logic [XLEN-1:0] IimmS,
  output logic [XLEN-1:0] IimmU,
  output logic [XLEN-1:0] Simm,
  output logic [XLEN-1:0] SBimm,
  output logic [XLEN-1:0] Uimm,
  output logic [XLEN-1:0] UJimm,
  output logic            dec_ill
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]     ins_q [DEPTH];
  logic [31:0]     ins_d [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [XLEN-1:0] pc_d  [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            push;
  logic            pop;
  logic [31:0]     head_ins;
  logic [XLEN-1:0] sext;

  // Handshake qualifiers depend only on registered state so fetch never sees decode's ready
  assign fetch_rdy = (cnt_q != FULL_CNT);
  assign dec_vld   = (cnt_q != '0);
  assign push      = fetch_vld & fetch_rdy & ~flush;
  assign pop       = dec_vld & dec_rdy & ~flush;

  // Next-state for pointers, occupancy and storage; flush wins over any handshake
  always_comb begin
    ins_d    = ins_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        ins_d[wr_ptr_q] = fetch_ins;
        pc_d[wr_ptr_q]  = fetch_pc;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - (PW+1)'(1);
      end
    end
  end

  // State registers; storage is cleared on reset so the idle outputs read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= ins_d[i];
        pc_q[i]  <= pc_d[i];
      end
    end
  end

  assign head_ins = ins_q[rd_ptr_q];
  assign dec_pc   = pc_q[rd_ptr_q];
  assign op       = head_ins[6:0];
  assign funct3   = head_ins[14:12];
  assign funct7   = head_ins[31:25];
  assign rs1      = head_ins[18:15];
  assign rs2      = head_ins[23:20];
  assign rd       = head_ins[10:7];
  assign shamt    = head_ins[24:20];
  assign sext     = {XLEN{head_ins[31]}};

  // Pre-formed immediates: start from the fill pattern, then overlay the low bits
  always_comb begin
    IimmS        = sext;
    IimmS[11:0]  = head_ins[31:20];
    IimmU        = '0;
    IimmU[11:0]  = head_ins[31:20];
    Simm         = sext;
    Simm[11:0]   = {head_ins[31:25], head_ins[11:7]};
    SBimm        = sext;
    SBimm[12:0]  = {head_ins[31], head_ins[7], head_ins[30:25], head_ins[11:8], 1'b0};
    Uimm         = '0;
    Uimm[31:0]   = {head_ins[31:12], 12'b0};
    UJimm        = sext;
    UJimm[20:0]  = {head_ins[31], head_ins[19:12], head_ins[20], head_ins[30:21], 1'b0};
  end

`ifdef RV32E_REGCHK_EN
  // Top bit of any register field set means x16..x31; decode qualifies this by format
  assign dec_ill = dec_vld & (head_ins[19] | head_ins[24] | head_ins[11]);
`else
  assign dec_ill = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - directed table-driven bench for if_id_buffer
module tb_if_id_buffer;

  localparam int XLEN = 32;

`ifdef RV32E_REGCHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            fetch_vld = 1'b0;
  logic            fetch_rdy;
  logic [31:0]     fetch_ins = '0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            dec_vld;
  logic            dec_rdy = 1'b0;
  logic [XLEN-1:0] dec_pc;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [3:0]      rs1, rs2, rd;
  logic [4:0]      shamt;
  logic [XLEN-1:0] IimmS, IimmU, Simm, SBimm, Uimm, UJimm;
  logic            dec_ill;

  if_id_buffer #(.DEPTH(2), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_ins(fetch_ins), .fetch_pc(fetch_pc),
    .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_pc(dec_pc),
    .op(op), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .shamt(shamt),
    .IimmS(IimmS), .IimmU(IimmU), .Simm(Simm), .SBimm(SBimm), .Uimm(Uimm), .UJimm(UJimm),
    .dec_ill(dec_ill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] iimms;
    logic [31:0] iimmu;
    logic [31:0] simm;
    logic [31:0] sbimm;
    logic [31:0] uimm;
    logic [31:0] ujimm;
    logic        ill;
  } vec_t;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;
    int pushed;
    int popped;

    //          ins           pc      op     f3    f7     rs1   rs2   rd    shamt  IimmS         IimmU         Simm          SBimm         Uimm          UJimm         ill
    vecs[0] = '{32'h00A30293, 32'h100, 7'h13, 3'd0, 7'h00, 4'h6, 4'hA, 4'h5, 5'h0A, 32'h0000000A, 32'h0000000A, 32'h00000005, 32'h00000804, 32'h00A30000, 32'h0003000A, 1'b0};
    vecs[1] = '{32'hFE000EE3, 32'h104, 7'h63, 3'd0, 7'h7F, 4'h0, 4'h0, 4'hD, 5'h00, 32'hFFFFFFE0, 32'h00000FE0, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFE000000, 32'hFFF007E0, 1'b1};
    vecs[2] = '{32'h01F00093, 32'h108, 7'h13, 3'd0, 7'h00, 4'h0, 4'hF, 4'h1, 5'h1F, 32'h0000001F, 32'h0000001F, 32'h00000001, 32'h00000800, 32'h01F00000, 32'h0000081E, 1'b1};
    vecs[3] = '{32'hFFF00113, 32'h10C, 7'h13, 3'd0, 7'h7F, 4'h0, 4'hF, 4'h2, 5'h1F, 32'hFFFFFFFF, 32'h00000FFF, 32'hFFFFFFE2, 32'hFFFFF7E2, 32'hFFF00000, 32'hFFF00FFE, 1'b1};
    vecs[4] = '{32'h123452B7, 32'h110, 7'h37, 3'd5, 7'h09, 4'h8, 4'h3, 4'h5, 5'h03, 32'h00000123, 32'h00000123, 32'h00000125, 32'h00000924, 32'h12345000, 32'h00045922, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_dec_vld",   32'(dec_vld),   32'd0);
    check("rst_fetch_rdy", 32'(fetch_rdy), 32'd1);
    check("rst_dec_pc",    dec_pc,         32'd0);
    check("rst_op",        32'(op),        32'd0);
    check("rst_rd",        32'(rd),        32'd0);
    check("rst_IimmS",     IimmS,          32'd0);
    check("rst_SBimm",     SBimm,          32'd0);
    check("rst_UJimm",     UJimm,          32'd0);
    check("rst_dec_ill",   32'(dec_ill),   32'd0);

    // Release reset away from any clock edge
    #3 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_dec_vld",   32'(dec_vld),   32'd0);
      check("post_rst_fetch_rdy", 32'(fetch_rdy), 32'd1);
    end

    // Table: push one word, check every dispatch field, pop it
    for (int i = 0; i < 5; i++) begin
      fetch_vld = 1'b1;
      fetch_ins = vecs[i].ins;
      fetch_pc  = vecs[i].pc;
      dec_rdy   = 1'b0;
      step();
      fetch_vld = 1'b0;
      check("vec_dec_vld", 32'(dec_vld),  32'd1);
      check("vec_dec_pc",  dec_pc,        vecs[i].pc);
      check("vec_op",      32'(op),       32'(vecs[i].op));
      check("vec_funct3",  32'(funct3),   32'(vecs[i].f3));
      check("vec_funct7",  32'(funct7),   32'(vecs[i].f7));
      check("vec_rs1",     32'(rs1),      32'(vecs[i].rs1));
      check("vec_rs2",     32'(rs2),      32'(vecs[i].rs2));
      check("vec_rd",      32'(rd),       32'(vecs[i].rd));
      check("vec_shamt",   32'(shamt),    32'(vecs[i].shamt));
      check("vec_IimmS",   IimmS,         vecs[i].iimms);
      check("vec_IimmU",   IimmU,         vecs[i].iimmu);
      check("vec_Simm",    Simm,          vecs[i].simm);
      check("vec_SBimm",   SBimm,         vecs[i].sbimm);
      check("vec_Uimm",    Uimm,          vecs[i].uimm);
      check("vec_UJimm",   UJimm,         vecs[i].ujimm);
      check("vec_dec_ill", 32'(dec_ill),  32'(vecs[i].ill & CHK));
      dec_rdy = 1'b1;
      step();
      dec_rdy = 1'b0;
      check("vec_pop_dec_vld", 32'(dec_vld), 32'd0);
      check("vec_pop_dec_ill", 32'(dec_ill), 32'd0);
    end

    // Fill to full, hold a third word, then drain in order
    fetch_vld = 1'b1; fetch_ins = 32'hFE000EE3; fetch_pc = 32'h200;
    step();
    check("fill_dec_vld",    32'(dec_vld),   32'd1);
    check("fill_SBimm",      SBimm,          32'hFFFFFFFC);
    check("fill_rdy_one",    32'(fetch_rdy), 32'd1);
    fetch_ins = 32'h00A30293; fetch_pc = 32'h204;
    step();
    check("fill_rdy_full",   32'(fetch_rdy), 32'd0);
    check("fill_head_a",     dec_pc,         32'h200);
    fetch_ins = 32'h01F00093; fetch_pc = 32'h208;
    step();
    check("fill_held_rdy",   32'(fetch_rdy), 32'd0);
    check("fill_held_head",  dec_pc,         32'h200);
    dec_rdy = 1'b1;
    #1;
    check("full_pop_rdy",    32'(fetch_rdy), 32'd0);
    step();
    check("drain_head_b",    dec_pc,         32'h204);
    check("drain_rdy_free",  32'(fetch_rdy), 32'd1);
    step();
    check("drain_head_c",    dec_pc,         32'h208);
    check("drain_c_vld",     32'(dec_vld),   32'd1);
    check("drain_c_rs2",     32'(rs2),       32'hF);
    fetch_vld = 1'b0;
    step();
    dec_rdy = 1'b0;
    check("drain_empty",     32'(dec_vld),   32'd0);

    // Move pointers off zero, fill, then flush with a push and pop pending
    fetch_vld = 1'b1; fetch_ins = 32'h00000013; fetch_pc = 32'h2FC;
    step();
    fetch_vld = 1'b0; dec_rdy = 1'b1;
    step();
    dec_rdy = 1'b0; fetch_vld = 1'b1; fetch_pc = 32'h300;
    step();
    fetch_pc = 32'h304;
    step();
    check("pre_flush_full",  32'(fetch_rdy), 32'd0);
    check("pre_flush_head",  dec_pc,         32'h300);
    fetch_pc = 32'h308; dec_rdy = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; fetch_vld = 1'b0; dec_rdy = 1'b0;
    check("flush_dec_vld",   32'(dec_vld),   32'd0);
    check("flush_fetch_rdy", 32'(fetch_rdy), 32'd1);
    check("flush_rd_ptr0",   dec_pc,         32'h304);
    step();
    check("flush_stay_empty", 32'(dec_vld),  32'd0);
    fetch_vld = 1'b1; fetch_pc = 32'h30C;
    step();
    fetch_vld = 1'b0;
    check("post_flush_head", dec_pc,         32'h30C);
    dec_rdy = 1'b1;
    step();
    dec_rdy = 1'b0;
    check("post_flush_empty", 32'(dec_vld),  32'd0);

    // Stream of 10 words with random decode stalls
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 200 && popped < 10; cyc++) begin
      fetch_vld = (pushed < 10);
      fetch_pc  = 32'h400 + 32'(pushed * 4);
      fetch_ins = 32'h00000013;
      dec_rdy   = 1'($urandom_range(0, 1));
      #1;
      if (dec_vld && dec_rdy) begin
        exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        check("stream_pc", dec_pc, exp_pc);
        popped++;
      end
      if (fetch_vld && fetch_rdy) begin
        exp_q.push_back(fetch_pc);
        pushed++;
      end
      step();
    end
    fetch_vld = 1'b0;
    dec_rdy = 1'b0;
    check("stream_popped", 32'(popped), 32'd10);
    check("stream_empty",  32'(dec_vld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Fetch-to-decode buffer.
- Accepts instruction words and their PCs from the fetch stage over a valid/ready handshake and stores them in a small circular FIFO.
- Presents the head entry to decode already split into the instruction-dispatch fields: op, funct3, funct7, rs1, rs2, rd, shamt and the pre-formed immediates.
- Decouples fetch stalls from decode stalls and discards wrong-path instructions on a branch/jump flush.

Parameters:
- DEPTH, 2, number of entries; power of 2, minimum 2.
- XLEN, 32, width of CpuType data, PCs and immediates.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all stored and incoming instructions this cycle.
- fetch_vld  in  1  fetch presents an instruction.
- fetch_rdy  out  1  buffer can accept an instruction.
- fetch_ins  in  32  instruction word.
- fetch_pc  in  XLEN  PC of fetch_ins.
- dec_vld  out  1  head entry valid.
- dec_rdy  in  1  decode consumes the head entry.
- dec_pc  out  XLEN  PC of the head entry.
- op  out  7  ins[6:0].
- funct3  out  3  ins[14:12].
- funct7  out  7  ins[31:25].
- rs1  out  4  ins[18:15].
- rs2  out  4  ins[23:20].
- rd  out  4  ins[10:7].
- shamt  out  5  ins[24:20].
- IimmS  out  XLEN  sign-extended ins[31:20].
- IimmU  out  XLEN  zero-extended ins[31:20].
- Simm  out  XLEN  sign-extended {ins[31:25],ins[11:7]}.
- SBimm  out  XLEN  sign-extended {ins[31],ins[7],ins[30:25],ins[11:8],1'b0}.
- Uimm  out  XLEN  {ins[31:12],12'b0}.
- UJimm  out  XLEN  sign-extended {ins[31],ins[19:12],ins[20],ins[30:21],1'b0}.
- dec_ill  out  1  register-index illegal flag (see Optional Feature).

Behaviour:
- Storage: DEPTH entries of {ins, pc}. Pointers wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally. Occupancy cnt is log2(DEPTH)+1 bits.
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, cnt=0, all storage cleared to 0. Resulting outputs: dec_vld=0, fetch_rdy=1, all field and immediate outputs 0, dec_pc=0, dec_ill=0.
- fetch_rdy = (cnt != DEPTH). It is purely registered-state based and must not depend on dec_rdy.
- push = fetch_vld & fetch_rdy & ~flush.
- pop = dec_vld & dec_rdy & ~flush.
- dec_vld = (cnt != 0).
- Latency: an instruction pushed in cycle N is visible with dec_vld=1 in cycle N+1. There is no combinational fetch-to-decode bypass.
- Push writes storage[wr_ptr] and increments wr_ptr. Pop increments rd_ptr. cnt is +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with dec_rdy=1: pop occurs, fetch_rdy stays 0 for that cycle, and the slot frees next cycle.
- Empty: dec_rdy is ignored. Outputs show storage[rd_ptr], which is stale and has no meaning while dec_vld=0.
- Flush (highest priority): next cycle cnt=0 and wr_ptr=rd_ptr=0. Storage is not cleared. Any same-cycle push or pop is suppressed.
- Field and immediate outputs are combinational slices of storage[rd_ptr]. Sign extension replicates ins[31] up to XLEN.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.

Optional Feature:
- Macro RV32E_REGCHK_EN.
- Defined: dec_ill = dec_vld & (ins[19] | ins[24] | ins[11]) of the head entry, i.e. an x16..x31 index in any register field. This is a conservative, format-agnostic RV32E check that decode qualifies by format.
- Undefined: dec_ill is tied to 0 and no extra logic is generated.

Test Plan:
- Reset then idle: dec_vld=0, fetch_rdy=1, all outputs 0. Release rst_n mid-cycle: no spurious dec_vld.
- Push ins=32'h00A30293 (addi x5,x6,10), pc=0x100; next cycle:
  - dec_vld=1, op=7'h13, rd=5, rs1=6, funct3=0.
  - IimmS=IimmU=10, dec_pc=0x100.
- Push ins=32'hFE000EE3 (beq x0,x0,-4) with dec_rdy=0, then push two more (DEPTH=2):
  - SBimm=32'hFFFFFFFC.
  - fetch_rdy=0 after the 2nd push; 3rd word held by fetch.
  - Raise dec_rdy: entries pop in order and the 3rd is accepted one cycle after the first pop.
- Full buffer, fetch_vld=1, dec_rdy=1 together with flush=1: next cycle dec_vld=0, cnt=0, no entry written.
- Continuous stream of 10 pushes and pops with random dec_rdy: pointer wrap verified, PCs emerge in issue order with none missing.
- With RV32E_REGCHK_EN: push 32'h01F00093 (rs2-field bit 24 set) -> dec_ill=1. Without the macro -> dec_ill=0.
